fetch_line_sequencer: RTL and testbench

Sequences instruction-memory line fetches for the front end. Issues aligned 128-bit line requests ahead of the consumer and buffers returned lines in order. Discards responses made stale by a redirect. Sits between the instruction-memory port and the prefetch queue, replacing free-running address generation with credit-limited, redirect-safe fetch control.

---
 rtl/fetch_line_sequencer_pkg.sv | 21 ++
 rtl/fetch_line_sequencer_line_fifo.sv | 64 ++++++
 rtl/fetch_line_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_line_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_line_sequencer_pkg.sv
// Shared configuration for the instruction fetch line sequencer: reset PC,
// line-address type and the layout of a buffered line entry.
package fetch_line_sequencer_pkg;

    localparam logic [31:0] resetVector = 32'h0000_1004;

    localparam int unsigned LINE_BITS  = 128;
    localparam int unsigned ENTRY_BITS = 32 + LINE_BITS;

    typedef logic [27:0] lineAddress_;

    typedef struct packed {
        logic [31:0]          address;
        logic [LINE_BITS-1:0] data;
    } line_entry_t;

    function automatic logic [31:0] line_base(input lineAddress_ line);
        return {line, 4'h0};
    endfunction

endpackage

// File: rtl/fetch_line_sequencer_line_fifo.sv
// Small synchronous FIFO with flush, used for both the line buffer and the
// in-flight address tags. Push and pop together on a full FIFO are both honoured.
module line_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
        if (do_push) wr_ptr_d = bump(wr_ptr_q);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy comes from count_q and consumers gate empty data.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_line_sequencer.sv
// Credit-limited, redirect-safe instruction line fetch: issues aligned line
// requests, tags them, and buffers live responses in order while dropping stale ones.
module fetch_line_sequencer
    import fetch_line_sequencer_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned BUFFER_LINES    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 redirect,
    input  logic [31:0]          redirectVector,
    output logic                 requestValid,
    output logic [31:0]          requestAddress,
    input  logic                 requestReady,
    input  logic                 responseValid,
    input  logic [LINE_BITS-1:0] responseData,
    output logic                 lineValid,
    output logic [LINE_BITS-1:0] lineData,
    output logic [31:0]          lineAddress,
    input  logic                 lineReady
);

    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BUF_CNT_W = $clog2(BUFFER_LINES + 1);

    lineAddress_      next_line_q, next_line_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] stale_q, stale_d;

    logic [BUF_CNT_W-1:0] line_count;
    logic [CNT_W-1:0]     tag_count;
    lineAddress_          tag_head;
    line_entry_t          line_head;
    line_entry_t          push_entry;

    logic accept;
    logic tracked;
    logic rsp;
    logic rsp_stale;
    logic rsp_live;

    // Credits come only from registered state so the request never combinationally depends on redirect.
    assign requestValid   = (32'(live_q) + 32'(stale_q) < 32'(MAX_OUTSTANDING)) &&
                            (32'(live_q) + 32'(line_count) < 32'(BUFFER_LINES));
    assign requestAddress = line_base(next_line_q);

    assign accept    = requestValid && requestReady;
    assign tracked   = (live_q != '0) || (stale_q != '0);
    assign rsp       = responseValid && tracked;
    assign rsp_stale = rsp && (stale_q != '0);
    assign rsp_live  = rsp && (stale_q == '0);

    always_comb begin
        next_line_d = next_line_q;
        live_d      = live_q;
        stale_d     = stale_q;
        if (redirect) begin
            next_line_d = redirectVector[31:4];
            live_d      = '0;
            stale_d     = CNT_W'(32'(stale_q) + 32'(live_q) + 32'(accept) - 32'(rsp));
        end else begin
            if (accept) next_line_d = next_line_q + 28'd1;
            live_d  = CNT_W'(32'(live_q) + 32'(accept) - 32'(rsp_live));
            stale_d = stale_q - CNT_W'(rsp_stale);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_line_q <= resetVector[31:4];
            live_q      <= '0;
            stale_q     <= '0;
        end else begin
            next_line_q <= next_line_d;
            live_q      <= live_d;
            stale_q     <= stale_d;
        end
    end

    line_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(lineAddress_)),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (1'b0),
        .push_i      (accept),
        .push_data_i (next_line_q),
        .pop_i       (rsp),
        .head_o      (tag_head),
        .count_o     (tag_count)
    );

    assign push_entry = '{address: line_base(tag_head), data: responseData};

    line_fifo #(
        .DEPTH (BUFFER_LINES),
        .WIDTH (ENTRY_BITS),
        .CNT_W (BUF_CNT_W)
    ) u_line_fifo (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (redirect),
        .push_i      (rsp_live && !redirect),
        .push_data_i (push_entry),
        .pop_i       (lineValid && lineReady && !redirect),
        .head_o      (line_head),
        .count_o     (line_count)
    );

    assign lineValid   = (line_count != '0);
    assign lineData    = lineValid ? line_head.data : '0;
    assign lineAddress = lineValid ? line_head.address : '0;

    a_no_untracked_response: assert property (@(posedge clock) disable iff (reset)
        responseValid |-> tracked);

    a_tags_match_credits: assert property (@(posedge clock) disable iff (reset)
        32'(tag_count) == 32'(live_q) + 32'(stale_q));

endmodule

// File: tb/tb_fetch_line_sequencer.sv
// Directed bench for fetch_line_sequencer: a cycle table for streaming and
// back-pressure, then hand sequences for redirect, wrap and mid-stream reset.
module tb_fetch_line_sequencer;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect;
    logic [31:0]  redirectVector;
    logic         requestValid;
    logic [31:0]  requestAddress;
    logic         requestReady;
    logic         responseValid;
    logic [127:0] responseData;
    logic         lineValid;
    logic [127:0] lineData;
    logic [31:0]  lineAddress;
    logic         lineReady;

    int checks   = 0;
    int failures = 0;

    fetch_line_sequencer #(
        .MAX_OUTSTANDING (2),
        .BUFFER_LINES    (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirectVector (redirectVector),
        .requestValid   (requestValid),
        .requestAddress (requestAddress),
        .requestReady   (requestReady),
        .responseValid  (responseValid),
        .responseData   (responseData),
        .lineValid      (lineValid),
        .lineData       (lineData),
        .lineAddress    (lineAddress),
        .lineReady      (lineReady)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_w;
        logic        lrdy;
        logic        exp_req_v;
        logic [31:0] exp_req_a;
        logic        exp_line_v;
        logic [31:0] exp_line_a;
        logic [31:0] exp_line_w;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rv, input logic [31:0] ra,
                              input logic lv, input logic [31:0] la, input logic [31:0] lw);
        check({tag, ".requestValid"},   128'(requestValid),   128'(rv));
        check({tag, ".requestAddress"}, 128'(requestAddress), 128'(ra));
        check({tag, ".lineValid"},      128'(lineValid),      128'(lv));
        check({tag, ".lineAddress"},    128'(lineAddress),    128'(la));
        check({tag, ".lineData"},       lineData,             {4{lw}});
    endtask

    task automatic drive(input logic rdy, input logic rsp_v, input logic [31:0] rsp_w,
                         input logic lrdy, input logic redir, input logic [31:0] vec);
        requestReady   = rdy;
        responseValid  = rsp_v;
        responseData   = {4{rsp_w}};
        lineReady      = lrdy;
        redirect       = redir;
        redirectVector = vec;
    endtask

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Latency-1 streaming with lineReady high, then back-pressure with lineReady low.
        //          rdy  rspv rsp_w          lrdy reqv req_a         linev line_a        line_w
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'hAAAA_1000, 1'b1, 1'b1, 32'h0000_1010, 1'b0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'hAAAA_1010, 1'b1, 1'b0, 32'h0000_1020, 1'b1, 32'h0000_1000, 32'hAAAA_1000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1020, 1'b1, 32'h0000_1010, 32'hAAAA_1010};
        vecs[4]  = '{1'b1, 1'b1, 32'hAAAA_1020, 1'b1, 1'b1, 32'h0000_1030, 1'b0, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b1, 32'hAAAA_1030, 1'b1, 1'b0, 32'h0000_1040, 1'b1, 32'h0000_1020, 32'hAAAA_1020};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1040, 1'b1, 32'h0000_1030, 32'hAAAA_1030};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1040, 1'b0, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'hAAAA_1040, 1'b0, 1'b1, 32'h0000_1050, 1'b0, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'hAAAA_1050, 1'b0, 1'b0, 32'h0000_1060, 1'b1, 32'h0000_1040, 32'hAAAA_1040};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_1060, 1'b1, 32'h0000_1040, 32'hAAAA_1040};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_1060, 1'b1, 32'h0000_1040, 32'hAAAA_1040};
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1060, 1'b1, 32'h0000_1050, 32'hAAAA_1050};
        vecs[13] = '{1'b1, 1'b1, 32'hAAAA_1060, 1'b0, 1'b0, 32'h0000_1070, 1'b1, 32'h0000_1050, 32'hAAAA_1050};
        vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_1070, 1'b1, 32'h0000_1050, 32'hAAAA_1050};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_1070, 1'b1, 32'h0000_1060, 32'hAAAA_1060};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1070, 1'b0, 32'h0,         32'h0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        tick();
        reset = 1'b0;
        expect_out("reset", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rdy, vecs[i].rsp_v, vecs[i].rsp_w, vecs[i].lrdy, 1'b0, 32'h0);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_req_v, vecs[i].exp_req_a,
                       vecs[i].exp_line_v, vecs[i].exp_line_a, vecs[i].exp_line_w);
            tick();
        end

        // Two requests in flight at latency 3, redirect drops both responses.
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c0", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c1", 1'b1, 32'h0000_1010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2008);
        expect_out("rdr.c2", 1'b0, 32'h0000_1020, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hBAD0_1000, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c3", 1'b0, 32'h0000_2000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hBAD0_1010, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c4", 1'b1, 32'h0000_2000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c5", 1'b1, 32'h0000_2010, 1'b0, 32'h0, 32'h0); tick();
        expect_out("rdr.c6", 1'b1, 32'h0000_2010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b1, 32'hAAAA_2000, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c7", 1'b1, 32'h0000_2010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rdr.c8", 1'b1, 32'h0000_2010, 1'b1, 32'h0000_2000, 32'hAAAA_2000);

        // Redirect coincident with an accept and a response.
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("coin.c0", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hAAAA_1000, 1'b1, 1'b1, 32'h0000_3000);
        expect_out("coin.c1", 1'b1, 32'h0000_1010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hBBBB_1010, 1'b0, 1'b0, 32'h0);
        expect_out("coin.c2", 1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b1, 32'hAAAA_3000, 1'b0, 1'b0, 32'h0);
        expect_out("coin.c3", 1'b1, 32'h0000_3010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("coin.c4", 1'b1, 32'h0000_3010, 1'b1, 32'h0000_3000, 32'hAAAA_3000);

        // Line address wraps from the top of the space to zero.
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        expect_out("wrap.c0", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap.c1", 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b1, 32'hAAAA_FFF0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap.c2", 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap.c3", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF0, 32'hAAAA_FFF0);

        // Reset with a full line buffer, coincident with a redirect.
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rst.c0", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hAAAA_1000, 1'b0, 1'b0, 32'h0);
        expect_out("rst.c1", 1'b1, 32'h0000_1010, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b1, 1'b1, 32'hAAAA_1010, 1'b0, 1'b0, 32'h0);
        expect_out("rst.c2", 1'b0, 32'h0000_1020, 1'b1, 32'h0000_1000, 32'hAAAA_1000); tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_5000);
        expect_out("rst.c3", 1'b0, 32'h0000_1020, 1'b1, 32'h0000_1000, 32'hAAAA_1000); tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rst.c4", 1'b1, 32'h0000_1000, 1'b0, 32'h0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("rst.c5", 1'b1, 32'h0000_1010, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
